// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and helpers for the multi-port register file
// Contents: clr_state_t (clear engine states), default WIDTH/DEPTH/PC_IDX, clog2_f()
package regfile_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
    localparam int WIDTH_D  = 32;
    localparam int DEPTH_D  = 16;
    localparam int PC_IDX_D = 15;
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy vector with set/clear/wipe and NRD lookup ports
// Ports: clk, rst_n (async active-low); set_v/set_a mark pending; clr_v/clr_a release;
//        wipe_v/wipe_a clear-engine wipe; ra -> rbusy lookups (combinational)
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int DEPTH = DEPTH_D,
    parameter int NRD   = 2,
    localparam int AW   = clog2_f(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_v,
    input  logic [AW-1:0]          set_a,
    input  logic                   clr_v,
    input  logic [AW-1:0]          clr_a,
    input  logic                   wipe_v,
    input  logic [AW-1:0]          wipe_a,
    input  logic [NRD-1:0][AW-1:0] ra,
    output logic [NRD-1:0]         rbusy
);
    logic [DEPTH-1:0] busy;
    // set is applied last so a new issue supersedes a same-cycle release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else begin
            if (wipe_v) busy[wipe_a] <= 1'b0;
            if (clr_v) busy[clr_a] <= 1'b0;
            if (set_v) busy[set_a] <= 1'b1;
        end
    always_comb
        for (int i = 0; i < NRD; i++) rbusy[i] = busy[ra[i]];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with PC alias, scoreboard and clear engine
// Ports: clk, rst_n (async active-low); ra -> rd/rbusy (combinational reads);
//        we0/wa0/wd0 ALU writeback, we1/wa1/wd1 load writeback (wins collisions);
//        pc_in returned for reads of PC_IDX; iss_v/iss_a mark pending;
//        clr_req starts clear, clr_busy/clr_done report it
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to reads
module regfile_mp import regfile_pkg::*; #(
    parameter int WIDTH  = WIDTH_D,
    parameter int DEPTH  = DEPTH_D,
    parameter int NRD    = 2,
    parameter int PC_IDX = PC_IDX_D,
    localparam int AW    = clog2_f(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0][AW-1:0]    ra,
    output logic [NRD-1:0][WIDTH-1:0] rd,
    output logic [NRD-1:0]            rbusy,
    input  logic                      we0,
    input  logic [AW-1:0]             wa0,
    input  logic [WIDTH-1:0]          wd0,
    input  logic                      we1,
    input  logic [AW-1:0]             wa1,
    input  logic [WIDTH-1:0]          wd1,
    input  logic [WIDTH-1:0]          pc_in,
    input  logic                      iss_v,
    input  logic [AW-1:0]             iss_a,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      clr_done
);
    localparam logic [AW-1:0] PCA = AW'(PC_IDX);
    logic [WIDTH-1:0] mem [DEPTH];
    clr_state_t state;
    // one spare bit so the terminal compare never aliases with wrap-around
    logic [AW:0] idx;
    logic [NRD-1:0] sb_busy;
    logic act, w0, w1, iv;
    assign act = state == IDLE;
    assign w0 = we0 && act;
    assign w1 = we1 && act;
    assign iv = iss_v && act;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state <= IDLE;
            idx <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: if (clr_req) begin
                    state <= CLEAR;
                    idx <= '0;
                    clr_busy <= 1'b1;
                end
                CLEAR: begin
                    mem[idx[AW-1:0]] <= '0;
                    idx <= idx + 1'b1;
                    if (idx == (AW+1)'(DEPTH-1)) begin
                        state <= DONE;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    clr_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (w0) mem[wa0] <= wd0;
            if (w1) mem[wa1] <= wd1;
        end
    regfile_scoreboard #(.DEPTH(DEPTH), .NRD(NRD)) u_sb (
        .clk(clk),
        .rst_n(rst_n),
        .set_v(iv),
        .set_a(iss_a),
        .clr_v(w1),
        .clr_a(wa1),
        .wipe_v(state == CLEAR),
        .wipe_a(idx[AW-1:0]),
        .ra(ra),
        .rbusy(sb_busy)
    );
    always_comb
        for (int i = 0; i < NRD; i++) begin
            rd[i] = mem[ra[i]];
            rbusy[i] = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
            rd[i] = (w0 && wa0 == ra[i]) ? wd0 : rd[i];
            rd[i] = (w1 && wa1 == ra[i]) ? wd1 : rd[i];
            rbusy[i] = (w1 && wa1 == ra[i]) ? 1'b0 : rbusy[i];
`endif
            rd[i] = (ra[i] == PCA) ? pc_in : rd[i];
            rbusy[i] = (ra[i] == PCA) ? 1'b0 : rbusy[i];
        end
endmodule
